// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver on the OS_RATE x baud clock.
// Optional 2-of-3 majority sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int OS_RATE     = 16
) (
  input  logic       clk_rf,
  input  logic       rst_rf,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW  = $clog2(OS_RATE);
  localparam int MID = OS_RATE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Decisions land MAJ cycles after the nominal sample point; the bit counter wraps past OS_RATE-1.
  localparam logic [CW-1:0] START_PT   = CW'(MID + MAJ);
  localparam logic [CW-1:0] BIT_PT     = CW'(OS_RATE - 1 + MAJ);
  localparam logic [CW-1:0] DATA_ENTRY = CW'(MAJ);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic [7:0]             rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_err_q;
  logic                   rx_s;
  logic                   sample;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_rf) begin
    if (rst_rf) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] holds rx_s from the nominal point, hist_q[1] from the cycle before it.
  logic [1:0] hist_q;

  always_ff @(posedge clk_rf) begin
    if (rst_rf) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rx_s};
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk_rf) begin
    if (rst_rf) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == START_PT) begin
            if (!sample) begin
              state_q   <= DATA;
              cnt_q     <= DATA_ENTRY;
              bit_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == BIT_PT) begin
            shift_q   <= {sample, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == BIT_PT) begin
            if (sample) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RECOVER;
            end
          end
        end
        // Hold off re-arming until the line is released, so a break does not retrigger.
        RECOVER: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver.
// Frame outcomes are predicted from line timing and byte values; strobes are logged and compared.
module tb_uart_receiver;

  localparam int S   = 2;
  localparam int OS  = 16;
  localparam int MID = OS / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Cycles from driving the start bit low to the strobe cycle.
  localparam int LAT = S + 153 + MAJ;

  logic       clk_rf = 1'b0;
  logic       rst_rf = 1'b1;
  logic       rx_in  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_receiver #(.SYNC_STAGES(S), .OS_RATE(OS)) dut (
    .clk_rf    (clk_rf),
    .rst_rf    (rst_rf),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk_rf = ~clk_rf;

  int cyc = 0;
  always @(posedge clk_rf) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;
  bit         both_hi = 1'b0;

  always @(negedge clk_rf) begin
    if (rx_valid || frame_err) begin
      obs_q.push_back('{cyc, frame_err, rx_data});
      if (rx_valid && frame_err) both_hi = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk_rf);
    #1;
  endtask

  // glitch_idx selects a frame bit (0 = start, 1..8 = data, 9 = stop) to invert for one cycle at its sample point.
  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int glitch_idx, output int n);
    logic [9:0] bits;
    bits = {stop_hi, b, 1'b0};
    n = cyc;
    for (int i = 0; i < 10; i++) begin
      for (int t = 0; t < OS; t++) begin
        rx_in = bits[i] ^ ((i == glitch_idx) && (t == MID + 1));
        tick();
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_rf = 1'b1;
    rx_in  = 1'b1;
    repeat (3) tick();
    rst_rf = 1'b0;
    tick();
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h expected 00", rx_data);
    end
    checks++;
    if ({rx_valid, frame_err, rx_busy} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {rx_valid, frame_err, rx_busy});
    end
    for (int i = 0; i < 500; i++) begin
      tick();
      checks++;
      if ({rx_valid, frame_err, rx_busy, rx_data} !== 11'd0) begin
        errors++;
        $display("FAIL idle_quiet: cycle %0d got v=%b fe=%b busy=%b data=%h expected all zero",
                 cyc, rx_valid, frame_err, rx_busy, rx_data);
        break;
      end
    end
  endtask

  task automatic test_single_byte();
    int n;
    obs_q.delete();
    send_frame(8'hA5, 1'b1, -1, n);
    last_good = 8'hA5;
    repeat (20) tick();
    checks++;
    if (obs_q.size() !== 1) begin
      errors++; $display("FAIL a5_count: got %0d strobes expected 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].err !== 1'b0 || obs_q[0].data !== 8'hA5) begin
        errors++; $display("FAIL a5_data: got err=%b data=%h expected err=0 data=a5", obs_q[0].err, obs_q[0].data);
      end
      checks++;
      if (obs_q[0].at !== n + LAT) begin
        errors++; $display("FAIL a5_latency: got %0d expected %0d", obs_q[0].at - n, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    obs_q.delete();
    send_frame(8'h00, 1'b1, -1, n0);
    send_frame(8'hFF, 1'b1, -1, n1);
    last_good = 8'hFF;
    repeat (20) tick();
    checks++;
    if (obs_q.size() !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d strobes expected 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].data !== 8'h00 || obs_q[1].data !== 8'hFF || obs_q[0].err || obs_q[1].err) begin
        errors++; $display("FAIL b2b_data: got %h,%h expected 00,ff", obs_q[0].data, obs_q[1].data);
      end
      checks++;
      if (obs_q[0].at !== n0 + LAT) begin
        errors++; $display("FAIL b2b_first_time: got %0d expected %0d", obs_q[0].at - n0, LAT);
      end
      checks++;
      if (obs_q[1].at - obs_q[0].at !== 160) begin
        errors++; $display("FAIL b2b_spacing: got %0d expected 160", obs_q[1].at - obs_q[0].at);
      end
    end
  endtask

  task automatic test_frame_error();
    int n, m, t;
    bit busy_drop;
    obs_q.delete();
    send_frame(8'h3C, 1'b0, -1, n);
    rx_in = 1'b0;
    busy_drop = 1'b0;
    repeat (40 * OS) begin
      tick();
      if (!rx_busy) busy_drop = 1'b1;
    end
    checks++;
    if (obs_q.size() !== 1) begin
      errors++; $display("FAIL ferr_count: got %0d strobes expected 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].err !== 1'b1 || obs_q[0].at !== n + LAT) begin
        errors++; $display("FAIL ferr_pulse: got err=%b at %0d expected err=1 at %0d", obs_q[0].err, obs_q[0].at - n, LAT);
      end
      checks++;
      if (obs_q[0].data !== last_good) begin
        errors++; $display("FAIL ferr_data_kept: got %h expected %h", obs_q[0].data, last_good);
      end
    end
    checks++;
    if (busy_drop) begin
      errors++; $display("FAIL ferr_busy_held: got busy low during break expected high");
    end
    m = cyc;
    rx_in = 1'b1;
    t = 0;
    while (rx_busy && t < 50) begin
      tick();
      t++;
    end
    checks++;
    if (cyc !== m + S + 1) begin
      errors++; $display("FAIL ferr_release: got busy low after %0d cycles expected %0d", cyc - m, S + 1);
    end
    obs_q.delete();
    send_frame(8'h55, 1'b1, -1, n);
    last_good = 8'h55;
    repeat (20) tick();
    checks++;
    if (obs_q.size() !== 1 || obs_q[0].data !== 8'h55 || obs_q[0].err !== 1'b0 || obs_q[0].at !== n + LAT) begin
      errors++; $display("FAIL ferr_next_frame: got %0d strobes first=%h expected 1 strobe 55",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 8'hxx);
    end
  endtask

  task automatic test_false_start();
    int n, cnt, first;
    obs_q.delete();
    n = cyc;
    cnt = 0;
    first = -1;
    for (int i = 0; i < 40; i++) begin
      rx_in = (i < 4) ? 1'b0 : 1'b1;
      tick();
      if (rx_busy) begin
        cnt++;
        if (first < 0) first = cyc;
      end
    end
    checks++;
    if (cnt !== MID + 1 + MAJ) begin
      errors++; $display("FAIL glitch_busy_len: got %0d expected %0d", cnt, MID + 1 + MAJ);
    end
    checks++;
    if (first !== n + S + 1) begin
      errors++; $display("FAIL glitch_busy_start: got %0d expected %0d", first - n, S + 1);
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL glitch_no_strobe: got %0d strobes expected 0", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    int n;
    obs_q.delete();
    bits = {1'b1, 8'hC3, 1'b0};
    for (int k = 0; k < 5 * OS + OS / 2; k++) begin
      rx_in = bits[k / OS];
      tick();
    end
    rst_rf = 1'b1;
    rx_in  = 1'b1;
    tick();
    rst_rf = 1'b0;
    last_good = 8'h00;
    checks++;
    if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin
      errors++; $display("FAIL rst_mid_state: got busy=%b data=%h expected busy=0 data=00", rx_busy, rx_data);
    end
    repeat (200) tick();
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL rst_mid_no_strobe: got %0d strobes expected 0", obs_q.size());
    end
    obs_q.delete();
    send_frame(8'h96, 1'b1, -1, n);
    last_good = 8'h96;
    repeat (20) tick();
    checks++;
    if (obs_q.size() !== 1 || obs_q[0].data !== 8'h96 || obs_q[0].err !== 1'b0 || obs_q[0].at !== n + LAT) begin
      errors++; $display("FAIL rst_mid_next_frame: got %0d strobes first=%h expected 1 strobe 96",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 8'hxx);
    end
  endtask

  task automatic test_random_frames();
    int n, gap;
    logic [7:0] b;
    exp_q.delete();
    obs_q.delete();
    for (int f = 0; f < 16; f++) begin
      gap = $urandom_range(0, 12);
      repeat (gap) tick();
      b = 8'($urandom);
      send_frame(b, 1'b1, -1, n);
      exp_q.push_back('{n + LAT, 1'b0, b});
      last_good = b;
    end
    repeat (20) tick();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i].at !== exp_q[i].at || obs_q[i].err !== exp_q[i].err || obs_q[i].data !== exp_q[i].data) begin
          errors++;
          $display("FAIL rand_frame%0d: got at=%0d err=%b data=%h expected at=%0d err=%b data=%h", i,
                   obs_q[i].at, obs_q[i].err, obs_q[i].data, exp_q[i].at, exp_q[i].err, exp_q[i].data);
        end
      end
    end
    checks++;
    if (both_hi) begin
      errors++; $display("FAIL strobe_exclusive: got rx_valid and frame_err together expected never");
    end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority_glitch();
    int n, k;
    for (int r = 0; r < 4; r++) begin
      obs_q.delete();
      k = $urandom_range(0, 7);
      send_frame(8'h81, 1'b1, k + 1, n);
      last_good = 8'h81;
      repeat (20) tick();
      checks++;
      if (obs_q.size() !== 1 || obs_q[0].data !== 8'h81 || obs_q[0].at !== n + LAT) begin
        errors++; $display("FAIL maj_glitch_bit%0d: got %0d strobes first=%h expected 1 strobe 81",
                           k, obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 8'hxx);
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_false_start();
    test_reset_mid_frame();
    test_random_frames();
`ifdef UART_RX_MAJORITY_EN
    test_majority_glitch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
